// File: rtl/alu_pkg.sv
// Shared ALU definitions: select-code enum, legality check and arbiter FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'b0000,
    SUB   = 4'b0001,
    AND   = 4'b0010,
    OR    = 4'b0011,
    XOR   = 4'b0100,
    SRL   = 4'b0101,
    SRA   = 4'b0110,
    SLL   = 4'b0111,
    SLT   = 4'b1000,
    SLTU  = 4'b1001,
    PASSB = 4'b1110,
    PASSA = 4'b1111
  } alusel_t;

  typedef enum logic {IDLE, HOLD} arb_state_t;

  localparam logic [3:0] SEL_NOGRANT = PASSA;

  function automatic logic is_legal_sel(input logic [3:0] sel);
    return !(sel inside {[4'b1010:4'b1101]});
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request scanning upward from ptr with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gidx,
  output logic            gvalid
);

  always_comb begin
    int unsigned idx;
    grant  = '0;
    gidx   = '0;
    gvalid = 1'b0;
    idx    = 0;
    if (en) begin
      for (int unsigned off = 0; off < NREQ; off++) begin
        idx = (32'(ptr) + off) % NREQ;
        if (!gvalid && req[idx]) begin
          grant[idx] = 1'b1;
          gidx       = IDW'(idx);
          gvalid     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one combinational ALU among NREQ requesters with a one-entry
// response register. Optional ownership lock enabled by macro ALU_ARB_LOCK_EN.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*4-1:0] req_sel,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
  output logic              lock_active,
`endif
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [3:0]        alu_sel,
  input  logic [31:0]       alu_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_err
);

  arb_state_t      state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            xfer;
  logic            can_accept;
  logic            advance;
  logic            sel_ok;

  assign rsp_valid  = (state == HOLD);
  assign can_accept = (state == IDLE) || (rsp_valid && rsp_ready);

`ifdef ALU_ARB_LOCK_EN
  logic           lock_q;
  logic [IDW-1:0] owner;

  assign lock_active = lock_q;
  assign eligible    = lock_q ? (req_valid & ({{(NREQ-1){1'b0}}, 1'b1} << owner))
                              : req_valid;
  // A locking transfer leaves the pointer alone; the releasing one advances it.
  assign advance     = !req_lock[gidx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
      owner  <= '0;
    end else if (xfer) begin
      lock_q <= req_lock[gidx];
      owner  <= gidx;
    end
  end
`else
  assign eligible = req_valid;
  assign advance  = 1'b1;
`endif

  // Reset gates the grant so req_ready reads zero while rst_n is low.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req    (eligible),
    .ptr    (ptr),
    .en     (can_accept && rst_n),
    .grant  (grant),
    .gidx   (gidx),
    .gvalid (xfer)
  );

  assign req_ready = grant;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = SEL_NOGRANT;
    if (xfer) begin
      alu_a   = req_a[32*gidx +: 32];
      alu_b   = req_b[32*gidx +: 32];
      alu_sel = req_sel[4*gidx +: 4];
    end
  end

  assign sel_ok = is_legal_sel(alu_sel);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (xfer) state_nxt = HOLD;
      HOLD: begin
        if (xfer)           state_nxt = HOLD;
        else if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_err  <= 1'b0;
      ptr      <= '0;
    end else if (xfer) begin
      rsp_data <= sel_ok ? alu_res : '0;
      rsp_id   <= gidx;
      rsp_err  <= !sel_ok;
      if (advance)
        ptr <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb (NREQ=2) with a behavioural ALU attached.
module tb_alu_share_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_sel;
`ifdef ALU_ARB_LOCK_EN
  logic [1:0]  req_lock;
  logic        lock_active;
`endif
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [0:0]  rsp_id;

  int n_cmp = 0;
  int n_bad = 0;

  alu_share_arb #(.NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
`ifdef ALU_ARB_LOCK_EN
    .req_lock    (req_lock),
    .lock_active (lock_active),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_res   (alu_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  // Illegal codes return junk so the response zeroing is visible.
  function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] s);
    case (s)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b0110: return $unsigned($signed(a) >>> b[4:0]);
      4'b0111: return a << b[4:0];
      4'b1000: return {31'b0, $signed(a) < $signed(b)};
      4'b1001: return {31'b0, a < b};
      4'b1110: return b;
      4'b1111: return a;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_res = alu_f(alu_a, alu_b, alu_sel);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] s);
    req_valid[i]      = v;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_sel[4*i +: 4] = s;
  endtask

  initial begin
    logic [1:0] exp_gnt;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    req_lock  = '0;
`endif
    #12;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data",  rsp_data, 32'd0);
    chk("rst_id",    32'(rsp_id), 32'd0);
    chk("rst_err",   32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_alusel", 32'(alu_sel), 32'hF);
`ifdef ALU_ARB_LOCK_EN
    chk("rst_lock", 32'(lock_active), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Single op: 5 - 3
    set_req(0, 1'b1, 32'd5, 32'd3, 4'b0001);
    rsp_ready = 1'b1;
    #1;
    chk("single_ready", 32'(req_ready), 32'b01);
    chk("single_alua",  alu_a, 32'd5);
    step();
    req_valid = '0;
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_data",  rsp_data, 32'd2);
    chk("single_id",    32'(rsp_id), 32'd0);
    chk("single_err",   32'(rsp_err), 32'd0);
    step();
    chk("drain_valid", 32'(rsp_valid), 32'd0);
    chk("drain_hold",  rsp_data, 32'd2);

    // Fairness: pointer now at 1, so grants go 1,0,1,0
    set_req(0, 1'b1, 32'd10, 32'd20, 4'b0000);
    set_req(1, 1'b1, 32'h8000_0000, 32'd4, 4'b0110);
    for (int i = 0; i < 4; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      chk("rr_ready", 32'(req_ready), 32'(exp_gnt));
      step();
      chk("rr_id",   32'(rsp_id), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_data", rsp_data, (i % 2 == 0) ? 32'hF800_0000 : 32'd30);
    end

    // Backpressure with a pending request on requester 1
    rsp_ready = 1'b0;
    set_req(0, 1'b0, 32'd0, 32'd0, 4'b0000);
    set_req(1, 1'b1, 32'h0000_00F0, 32'h0000_003C, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data",  rsp_data, 32'd30);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_accept", 32'(req_ready), 32'b10);
    step();
    req_valid = '0;
    chk("bp_new_valid", 32'(rsp_valid), 32'd1);
    chk("bp_new_data",  rsp_data, 32'h0000_00CC);
    chk("bp_new_id",    32'(rsp_id), 32'd1);
    step();
    chk("bp_idle",      32'(rsp_valid), 32'd0);
    chk("bp_hold_data", rsp_data, 32'h0000_00CC);

    // Illegal select code
    set_req(0, 1'b1, 32'd1, 32'd2, 4'b1011);
    #1;
    chk("ill_ready",  32'(req_ready), 32'b01);
    chk("ill_alusel", 32'(alu_sel), 32'hB);
    step();
    req_valid = '0;
    chk("ill_valid", 32'(rsp_valid), 32'd1);
    chk("ill_err",   32'(rsp_err), 32'd1);
    chk("ill_data",  rsp_data, 32'd0);
    step();

    // Asynchronous reset while holding a response
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 32'd1, 32'd1, 4'b0000);
    #1;
    chk("ar_ready", 32'(req_ready), 32'b10);
    step();
    chk("ar_hold", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(rsp_valid), 32'd0);
    chk("ar_data",  rsp_data, 32'd0);
    chk("ar_gate",  32'(req_ready), 32'd0);
    req_valid = '0;
    #2;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'd1, 32'd1, 4'b0000);
    set_req(1, 1'b1, 32'd9, 32'd4, 4'b0001);
    #1;
    chk("ar_first", 32'(req_ready), 32'b01);
    step();
    chk("ar_first_id", 32'(rsp_id), 32'd0);

`ifdef ALU_ARB_LOCK_EN
    // Requester 1 locks for four ops, then releases
    req_lock = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lk_ready", 32'(req_ready), 32'b10);
      step();
      chk("lk_id",     32'(rsp_id), 32'd1);
      chk("lk_data",   rsp_data, 32'd5);
      chk("lk_active", 32'(lock_active), 32'd1);
    end
    req_lock = 2'b00;
    #1;
    chk("lk_rel_ready", 32'(req_ready), 32'b10);
    step();
    chk("lk_rel_active", 32'(lock_active), 32'd0);
    #1;
    chk("lk_next_ready", 32'(req_ready), 32'b01);
    step();
    chk("lk_next_id", 32'(rsp_id), 32'd0);
`endif

    req_valid = '0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Time-shares the single combinational ALU between NREQ requesters, e.g. the execute stage and the branch/address-generation unit.
- Round-robin grant with per-requester valid/ready handshake.
- The ALU operand/select ports are driven from the granted request, and the ALU result is captured into a one-entry response register with an id tag.
- Sits between the requesters and the ALU instance inside top.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ) (min 1), width of requester id.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_a  in  NREQ*32  packed operand A; slice i belongs to requester i.
- req_b  in  NREQ*32  packed operand B.
- req_sel  in  NREQ*4  packed ALU select code.
- alu_a  out  32  to ALU input_a.
- alu_b  out  32  to ALU input_b.
- alu_sel  out  4  to ALU alusel.
- alu_res  in  32  from ALU aluout, combinational.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  32  captured result.
- rsp_id  out  IDW  requester that owns the response.
- rsp_err  out  1  select code was illegal.

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, req_ready=0.
  - Round-robin pointer = 0. FSM = IDLE.
- FSM states:
  - IDLE: response register empty.
  - HOLD: response register full.
- can_accept = (state==IDLE) | (rsp_valid & rsp_ready).
- Grant (combinational):
  - When can_accept, pick the first requester with req_valid set, scanning from the pointer upward with wrap (NREQ-1 -> 0).
  - req_ready[g]=1 only for that requester; all other bits 0.
  - If no requester is valid, or can_accept=0, req_ready is all 0.
- ALU drive:
  - alu_a/alu_b/alu_sel = slice of the granted requester.
  - When there is no grant, drive 0, 0, 4'b1111 (pass A of zero).
- Transfer occurs on req_valid[g] & req_ready[g]. On that edge:
  - rsp_data <= alu_res, rsp_id <= g, rsp_err <= illegal(sel), rsp_valid <= 1.
  - Pointer <= g+1 mod NREQ.
  - Next state = HOLD.
- Latency: request accepted in cycle N -> rsp_valid=1 in cycle N+1. Throughput is 1 op/cycle when rsp_ready is held high.
- HOLD with rsp_ready=0: all outputs stable, req_ready all 0.
- HOLD with rsp_ready=1 and no new transfer: -> IDLE, rsp_valid <= 0. rsp_data/rsp_id hold their last values.
- Simultaneous drain and accept in the same cycle: stay in HOLD, load the new result. There is no bubble.
- Legal sel codes: 0000–1001, 1110, 1111.
- Illegal sel codes (1010–1101):
  - Still accepted and consume a slot.
  - rsp_data <= 0, rsp_err <= 1.
  - alu_sel is still driven with the raw code.
- SLT/SLTU results are passed through as delivered by the ALU. No extension is done here; aluout bits [31:1] are the ALU's concern.
- Requesters must hold valid/a/b/sel stable until ready. Dropping valid before ready is legal and cancels the request with no side effect.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- With the macro defined:
  - Extra input req_lock [NREQ].
  - When requester g transfers with req_lock[g]=1, it becomes the owner. Until the owner's next transfer with lock=0, only the owner can be granted and the pointer does not advance.
  - Extra output lock_active (1 bit, reset 0).
  - The lock survives HOLD backpressure and is cleared by reset.
- Without the macro: no req_lock/lock_active ports, pure round-robin.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [3:0] alusel_t (ADD, SUB, AND, OR, XOR, SRL, SRA, SLL, SLT, SLTU, PASSB, PASSA).
  - Function is_legal_sel().
  - typedef enum arb_state_t {IDLE, HOLD}.
- Sub-module rr_arbiter (parameter NREQ): inputs req vector, pointer, enable; outputs one-hot grant and grant index.

Test Plan:
- Reset: rst_n low mid-HOLD -> rsp_valid drops to 0 immediately (asynchronous); after release the first grant goes to requester 0.
- Single op: req0 a=5, b=3, sel=0001, rsp_ready=1 -> cycle+1 rsp_valid=1, data=2, id=0, err=0.
- Fairness: both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1. Req1 a=0x80000000, b=4, sel=0110 -> 0xF8000000.
- Backpressure: rsp_ready=0 for 3 cycles after a response -> rsp_data stable, req_ready=0. Raising rsp_ready with a pending request -> drain and new accept in the same cycle.
- Illegal code: sel=1011 -> accepted, rsp_err=1, rsp_data=0.
- ALU_ARB_LOCK_EN: req1 locks, both valid for 4 ops -> all 4 granted to req1. Req1 then sends lock=0 -> the next grant goes to req0.
